// File: rtl/vector_lane_compactor.sv
// Packs valid bytes from 20-lane masked input beats into dense 16-lane output words.
// A residue buffer carries leftover bytes into the next word and is drained on in_last.
module vector_lane_compactor #(
  parameter int IN_LANES  = 20,
  parameter int OUT_LANES = 16,
  parameter int LANE_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_LANES*LANE_W-1:0]    in_data,
  input  logic [IN_LANES-1:0]           in_mask,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [OUT_LANES*LANE_W-1:0]   out_data,
  output logic [4:0]                    out_bytes,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int BUF_LANES = IN_LANES + OUT_LANES - 1;
  localparam int CNT_W     = $clog2(BUF_LANES + 1);
  localparam int BUF_W     = BUF_LANES * LANE_W;
  localparam int IN_W      = IN_LANES * LANE_W;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_pop, pop, pc;
  logic [BUF_W-1:0]       lane_buf, buf_nxt, buf_sh;
  logic [IN_W-1:0]        packed_in;
  logic                   in_fire, out_fire;

  // Lanes >= cnt are always zero, so the low OUT_LANES lanes are already a clean output word.
  assign out_valid = (state == FLUSH) || (cnt >= CNT_W'(OUT_LANES));
  assign out_bytes = (cnt >= CNT_W'(OUT_LANES)) ? 5'(OUT_LANES) : cnt[4:0];
  assign out_last  = (state == FLUSH) && (cnt <= CNT_W'(OUT_LANES));
  assign out_data  = lane_buf[OUT_LANES*LANE_W-1:0];

  // With out_ready the pop of 16 bytes frees room before the append, so cnt never exceeds 35.
  assign in_ready  = (state == RUN) &&
                     ((cnt < CNT_W'(OUT_LANES)) || ((cnt < CNT_W'(2*OUT_LANES)) && out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    packed_in = '0;
    pc        = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      if (in_mask[i]) begin
        packed_in[LANE_W*pc +: LANE_W] = in_data[LANE_W*i +: LANE_W];
        pc = pc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pop     = out_fire ? CNT_W'(out_bytes) : '0;
    cnt_pop = cnt - pop;
    buf_sh  = lane_buf >> (LANE_W * pop);
    buf_nxt = buf_sh;
    cnt_nxt = cnt_pop;
    if (in_fire) begin
      buf_nxt = buf_sh | (BUF_W'(packed_in) << (LANE_W * cnt_pop));
      cnt_nxt = cnt_pop + pc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (in_fire && in_last) state_nxt = FLUSH;
      FLUSH:   if (out_fire && out_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // The buffer is cleared on reset as well so no stale bytes survive an aborted flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      lane_buf <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lane_buf <= buf_nxt;
    end
  end

endmodule

// File: tb/tb_vector_lane_compactor.sv
// Directed bench for vector_lane_compactor with hand-computed expected words.
module tb_vector_lane_compactor;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] in_data;
  logic [19:0]  in_mask;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  vector_lane_compactor dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] ramp(input int base);
    logic [159:0] v = '0;
    for (int i = 0; i < 20; i++) v[8*i +: 8] = 8'(base + i);
    return v;
  endfunction

  function automatic logic [127:0] word(input int base, input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [159:0] d, input logic [19:0] m, input logic l);
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mask  = '0;
    in_data  = '0;
  endtask

  initial begin
    logic [127:0] sparse_exp;
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_last",  128'(out_last),  128'(0));
    check("rst_out_bytes", 128'(out_bytes), 128'(0));
    check("rst_out_data",  out_data,        128'(0));

    // Full masks, ramp over two beats
    drive(ramp(0), 20'hFFFFF, 1'b0);
    tick();
    check("t1_b0_valid", 128'(out_valid), 128'(1));
    check("t1_b0_data",  out_data,        word(8'h00, 16));
    check("t1_b0_bytes", 128'(out_bytes), 128'(16));
    drive(ramp(8'h14), 20'hFFFFF, 1'b0);
    check("t1_ready_b1", 128'(in_ready), 128'(1));
    tick();
    idle();
    check("t1_b1_data",  out_data,        word(8'h10, 16));
    check("t1_b1_bytes", 128'(out_bytes), 128'(16));
    check("t1_b1_last",  128'(out_last),  128'(0));
    tick();
    check("t1_cnt8_novalid", 128'(out_valid), 128'(0));

    // Flush the 8-byte residue
    drive('0, 20'h0, 1'b1);
    tick();
    idle();
    check("t2_valid", 128'(out_valid), 128'(1));
    check("t2_bytes", 128'(out_bytes), 128'(8));
    check("t2_last",  128'(out_last),  128'(1));
    check("t2_data",  out_data,        word(8'h20, 8));
    tick();
    check("t2_ready_after", 128'(in_ready),  128'(1));
    check("t2_idle_valid",  128'(out_valid), 128'(0));

    // Sparse masks
    drive(ramp(0), 20'h00005, 1'b0);
    tick();
    check("t3_partial_novalid", 128'(out_valid), 128'(0));
    drive(ramp(0), 20'h80000, 1'b1);
    tick();
    idle();
    sparse_exp = 128'h13_02_00;
    check("t3_data",  out_data,        sparse_exp);
    check("t3_bytes", 128'(out_bytes), 128'(3));
    check("t3_last",  128'(out_last),  128'(1));
    tick();

    // Backpressure
    out_ready = 1'b0;
    drive(ramp(0), 20'hFFFFF, 1'b0);
    #1;
    check("t4_ready_b0", 128'(in_ready), 128'(1));
    tick();
    drive(ramp(8'h14), 20'hFFFFF, 1'b0);
    #1;
    check("t4_ready_blocked", 128'(in_ready), 128'(0));
    for (int c = 0; c < 10; c++) begin
      check("t4_hold_data",  out_data,        word(8'h00, 16));
      check("t4_hold_valid", 128'(out_valid), 128'(1));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4_ready_release", 128'(in_ready), 128'(1));
    tick();
    idle();
    check("t4_b1_data", out_data, word(8'h10, 16));
    tick();
    drive('0, 20'h0, 1'b1);
    tick();
    idle();
    check("t4_flush_data",  out_data,        word(8'h20, 8));
    check("t4_flush_bytes", 128'(out_bytes), 128'(8));
    check("t4_flush_last",  128'(out_last),  128'(1));
    tick();

    // Empty flush
    drive('0, 20'h0, 1'b1);
    tick();
    idle();
    check("t5_valid", 128'(out_valid), 128'(1));
    check("t5_bytes", 128'(out_bytes), 128'(0));
    check("t5_last",  128'(out_last),  128'(1));
    tick();
    check("t5_single_beat", 128'(out_valid), 128'(0));

    // Reset during flush with 12 bytes buffered
    out_ready = 1'b0;
    drive(ramp(8'h40), 20'h00FFF, 1'b1);
    tick();
    idle();
    check("t6_flush_bytes", 128'(out_bytes), 128'(12));
    check("t6_flush_ready", 128'(in_ready),  128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 128'(out_valid), 128'(0));
    check("t6_rst_ready", 128'(in_ready),  128'(1));
    check("t6_rst_data",  out_data,        128'(0));
    out_ready = 1'b1;
    drive(ramp(8'h80), 20'h00003, 1'b1);
    tick();
    idle();
    check("t6_new_data",  out_data,        word(8'h80, 2));
    check("t6_new_bytes", 128'(out_bytes), 128'(2));
    check("t6_new_last",  128'(out_last),  128'(1));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
